// File: rtl/reg_read_stage_pkg.sv
// Shared basic types and constants for the decode/read/writeback path.
package reg_read_stage_pkg;

   typedef logic [31:0] UIntX;
   typedef logic [31:0] Addr;
   typedef logic [31:0] Inst;
   typedef logic [7:0]  IId;

   typedef enum logic {
      REN_X = 1'b0,
      REN_S = 1'b1
   } ren_t;

   typedef struct packed {
      ren_t       rf_wen;
      logic [4:0] wb_addr;
   } Ctrl;

   localparam IId          IID_RANDOM = 8'hA5;
   localparam int unsigned REG_COUNT  = 32;

   // x0 writes are architecturally discarded, so they never count as writes.
   function automatic logic writes_reg(input Ctrl c);
      return (c.rf_wen == REN_S) && (c.wb_addr != 5'd0);
   endfunction

endpackage

// File: rtl/reg_read_stage_scoreboard.sv
// Per-register pending-write counters with writeback retire detection.
module reg_scoreboard
   import reg_read_stage_pkg::*;
#(
   parameter int unsigned SB_CNT_W = 2
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       wb_valid,
   input  IId         wb_inst_id,
   input  logic       wb_wen,
   input  logic [4:0] wb_addr,
   output logic       retire_en,
   output logic [4:0] retire_addr,
   input  logic       issue_en,
   input  logic [4:0] issue_addr,
   input  logic       hold_en,
   input  logic [4:0] hold_addr,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       rd_wen,
   input  logic [4:0] rd,
   output logic       busy1,
   output logic       busy2,
   output logic       full_rd
);

   localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);
   localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

   logic [SB_CNT_W-1:0] pend [REG_COUNT];
   IId                  saved_wb_id;
   logic                wb_new;
   logic                ret1, ret2, ret_rd, hold1, hold2, hold_rd;
   logic [SB_CNT_W:0]   rd_load, rd_limit;

   assign wb_new      = wb_valid && (wb_inst_id != saved_wb_id);
   assign retire_en   = wb_new && wb_wen;
   assign retire_addr = wb_addr;

   always_comb begin
      ret1    = retire_en && (retire_addr == rs1);
      ret2    = retire_en && (retire_addr == rs2);
      ret_rd  = retire_en && (retire_addr == rd);
      hold1   = hold_en && (hold_addr == rs1);
      hold2   = hold_en && (hold_addr == rs2);
      hold_rd = hold_en && (hold_addr == rd);
      // A retiring last write frees the source in the same cycle.
      busy1 = (rs1 != 5'd0) &&
              (hold1 || ((pend[rs1] != '0) && !(ret1 && (pend[rs1] == CNT_ONE))));
      busy2 = (rs2 != 5'd0) &&
              (hold2 || ((pend[rs2] != '0) && !(ret2 && (pend[rs2] == CNT_ONE))));
      // The writer held downstream will be counted before this one, so include it.
      rd_load  = {1'b0, pend[rd]} + {{SB_CNT_W{1'b0}}, hold_rd};
      rd_limit = {1'b0, CNT_MAX} + {{SB_CNT_W{1'b0}}, ret_rd};
      full_rd  = rd_wen && (rd_load >= rd_limit);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         saved_wb_id <= IID_RANDOM;
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            pend[i] <= '0;
         end
      end else begin
         if (wb_valid) begin
            saved_wb_id <= wb_inst_id;
         end
         pend[0] <= '0;
         for (int unsigned i = 1; i < REG_COUNT; i++) begin
            if (issue_en && (issue_addr == 5'(i)) && !(retire_en && (retire_addr == 5'(i)))) begin
               pend[i] <= pend[i] + CNT_ONE;
            end else if (retire_en && (retire_addr == 5'(i)) && !(issue_en && (issue_addr == 5'(i)))) begin
               pend[i] <= pend[i] - CNT_ONE;
            end
         end
      end
   end

endmodule

// File: rtl/reg_read_stage.sv
// Operand-read stage: hazard-checked register reads with writeback forwarding.
module reg_read_stage
   import reg_read_stage_pkg::*;
#(
   parameter int unsigned SB_CNT_W = 2
)
(
   input  logic       clk,
   input  logic       reset,
   input  UIntX       regfile [REG_COUNT],
   input  logic       flush,
   input  logic       id_valid,
   output logic       id_ready,
   input  Addr        id_pc,
   input  Inst        id_inst,
   input  IId         id_inst_id,
   input  Ctrl        id_ctrl,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       wb_valid,
   input  IId         wb_inst_id,
   input  Ctrl        wb_ctrl,
   input  UIntX       wb_wdata,
   output logic       ds_valid,
   input  logic       ds_ready,
   output Addr        ds_pc,
   output Inst        ds_inst,
   output IId         ds_inst_id,
   output Ctrl        ds_ctrl,
   output UIntX       ds_op1,
   output UIntX       ds_op2
);

   logic       retire_en;
   logic [4:0] retire_addr;
   logic       busy1, busy2, full_rd;
   logic       hold_en, issue_en, id_fire;
   logic       id_wen, wb_wen;
   UIntX       op1, op2;

   assign id_wen   = writes_reg(id_ctrl);
   assign wb_wen   = writes_reg(wb_ctrl);
   assign hold_en  = ds_valid && writes_reg(ds_ctrl);
   // A flushed instruction never reaches execute, so it is never counted.
   assign issue_en = hold_en && ds_ready && !flush;

   reg_scoreboard #(.SB_CNT_W(SB_CNT_W)) u_sb (
      .clk         (clk),
      .reset       (reset),
      .wb_valid    (wb_valid),
      .wb_inst_id  (wb_inst_id),
      .wb_wen      (wb_wen),
      .wb_addr     (wb_ctrl.wb_addr),
      .retire_en   (retire_en),
      .retire_addr (retire_addr),
      .issue_en    (issue_en),
      .issue_addr  (ds_ctrl.wb_addr),
      .hold_en     (hold_en),
      .hold_addr   (ds_ctrl.wb_addr),
      .rs1         (id_rs1),
      .rs2         (id_rs2),
      .rd_wen      (id_wen),
      .rd          (id_ctrl.wb_addr),
      .busy1       (busy1),
      .busy2       (busy2),
      .full_rd     (full_rd)
   );

   always_comb begin
      op1 = regfile[id_rs1];
      if (retire_en && (retire_addr == id_rs1)) begin
         op1 = wb_wdata;
      end
      if (id_rs1 == 5'd0) begin
         op1 = '0;
      end
      op2 = regfile[id_rs2];
      if (retire_en && (retire_addr == id_rs2)) begin
         op2 = wb_wdata;
      end
      if (id_rs2 == 5'd0) begin
         op2 = '0;
      end
   end

   assign id_ready = !(busy1 || busy2 || full_rd) && (!ds_valid || ds_ready) && !flush;
   assign id_fire  = id_valid && id_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         ds_valid   <= 1'b0;
         ds_pc      <= '0;
         ds_inst    <= '0;
         ds_inst_id <= '0;
         ds_ctrl    <= '0;
         ds_op1     <= '0;
         ds_op2     <= '0;
      end else begin
         if (flush) begin
            ds_valid <= 1'b0;
         end else if (id_fire) begin
            ds_valid <= 1'b1;
         end else if (ds_ready) begin
            ds_valid <= 1'b0;
         end
         if (id_fire) begin
            ds_pc      <= id_pc;
            ds_inst    <= id_inst;
            ds_inst_id <= id_inst_id;
            ds_ctrl    <= id_ctrl;
            ds_op1     <= op1;
            ds_op2     <= op2;
         end
      end
   end

endmodule

// File: tb/tb_reg_read_stage.sv
// Self-checking bench for reg_read_stage against a behavioural model.
module tb_reg_read_stage;
   import reg_read_stage_pkg::*;

   localparam int unsigned SBW     = 2;
   localparam int          CNT_MAX = 3;

   logic       clk = 1'b0;
   logic       reset;
   UIntX       regfile [REG_COUNT];
   logic       flush, id_valid, id_ready;
   Addr        id_pc;
   Inst        id_inst;
   IId         id_inst_id;
   Ctrl        id_ctrl;
   logic [4:0] id_rs1, id_rs2;
   logic       wb_valid;
   IId         wb_inst_id;
   Ctrl        wb_ctrl;
   UIntX       wb_wdata;
   logic       ds_valid, ds_ready;
   Addr        ds_pc;
   Inst        ds_inst;
   IId         ds_inst_id;
   Ctrl        ds_ctrl;
   UIntX       ds_op1, ds_op2;

   always #5 clk = ~clk;

   reg_read_stage #(.SB_CNT_W(SBW)) dut (
      .clk(clk), .reset(reset), .regfile(regfile), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
      .id_inst_id(id_inst_id), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .wb_valid(wb_valid), .wb_inst_id(wb_inst_id), .wb_ctrl(wb_ctrl), .wb_wdata(wb_wdata),
      .ds_valid(ds_valid), .ds_ready(ds_ready), .ds_pc(ds_pc), .ds_inst(ds_inst),
      .ds_inst_id(ds_inst_id), .ds_ctrl(ds_ctrl), .ds_op1(ds_op1), .ds_op2(ds_op2)
   );

   // Reference model state
   int   m_pend [REG_COUNT];
   IId   m_saved;
   bit   m_dsv, m_fired;
   Addr  m_pc;
   Inst  m_inst;
   IId   m_iid;
   Ctrl  m_ctrl;
   UIntX m_op1, m_op2;
   int   q_wr[$];
   IId   wb_id_ctr = 8'h00;
   int   vectors = 0;
   int   miscompares = 0;
   Addr  held_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit wr(input Ctrl c);
      return (c.rf_wen == REN_S) && (c.wb_addr != 5'd0);
   endfunction

   function automatic bit src_blk(input int s, input bit ret, input int ra);
      if (s == 0) return 1'b0;
      return ((m_pend[s] - ((ret && ra == s) ? 1 : 0)) > 0) ||
             (m_dsv && wr(m_ctrl) && int'(m_ctrl.wb_addr) == s);
   endfunction

   function automatic UIntX operand(input int s, input bit ret, input int ra);
      if (s == 0) return '0;
      if (ret && ra == s) return wb_wdata;
      return regfile[s];
   endfunction

   task automatic model_reset();
      m_dsv = 0; m_saved = IID_RANDOM; q_wr.delete();
      m_pc = '0; m_inst = '0; m_iid = '0; m_ctrl = '0; m_op1 = '0; m_op2 = '0;
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
   endtask

   task automatic step();
      bit   wb_new, ret, b1, b2, brd, exp_ready, issue, hold_rd;
      int   ra, rd;
      UIntX o1, o2;
      @(negedge clk);
      wb_new  = wb_valid && (wb_inst_id != m_saved);
      ret     = wb_new && wr(wb_ctrl);
      ra      = int'(wb_ctrl.wb_addr);
      rd      = int'(id_ctrl.wb_addr);
      b1      = src_blk(int'(id_rs1), ret, ra);
      b2      = src_blk(int'(id_rs2), ret, ra);
      hold_rd = m_dsv && wr(m_ctrl) && int'(m_ctrl.wb_addr) == rd;
      brd     = wr(id_ctrl) && ((m_pend[rd] + int'(hold_rd) - int'(ret && ra == rd)) >= CNT_MAX);
      exp_ready = !(b1 || b2 || brd) && (!m_dsv || ds_ready) && !flush;
      o1 = operand(int'(id_rs1), ret, ra);
      o2 = operand(int'(id_rs2), ret, ra);
      issue = m_dsv && ds_ready && !flush && wr(m_ctrl);
      if (!reset) chk("id_ready", 32'(id_ready), 32'(exp_ready));
      m_fired = !reset && id_valid && exp_ready;
      @(posedge clk);
      #1;
      if (reset) begin
         model_reset();
      end else begin
         if (wb_valid) m_saved = wb_inst_id;
         if (issue) begin
            m_pend[m_ctrl.wb_addr]++;
            q_wr.push_back(int'(m_ctrl.wb_addr));
         end
         if (ret) begin
            m_pend[ra]--;
            regfile[ra] = wb_wdata;
         end
         if (flush) m_dsv = 0;
         else if (m_fired) begin
            m_dsv = 1; m_pc = id_pc; m_inst = id_inst; m_iid = id_inst_id;
            m_ctrl = id_ctrl; m_op1 = o1; m_op2 = o2;
         end else if (ds_ready) m_dsv = 0;
      end
      chk("ds_valid", 32'(ds_valid), 32'(m_dsv));
      if (m_dsv || reset) begin
         chk("ds_pc", ds_pc, m_pc);
         chk("ds_inst", ds_inst, m_inst);
         chk("ds_inst_id", 32'(ds_inst_id), 32'(m_iid));
         chk("ds_ctrl", 32'(ds_ctrl), 32'(m_ctrl));
         chk("ds_op1", ds_op1, m_op1);
         chk("ds_op2", ds_op2, m_op2);
      end
      for (int i = 0; i < 32; i++)
         chk($sformatf("pend[%0d]", i), 32'(dut.u_sb.pend[i]), 32'(m_pend[i]));
   endtask

   task automatic offer(input int rd, input bit w, input int r1, input int r2);
      id_valid = 1'b1;
      id_ctrl.rf_wen  = w ? REN_S : REN_X;
      id_ctrl.wb_addr = 5'(rd);
      id_rs1 = 5'(r1); id_rs2 = 5'(r2);
      id_pc = $urandom; id_inst = $urandom; id_inst_id = 8'($urandom);
   endtask

   // Present the next in-order retire (or a non-writing writeback) with a fresh id.
   task automatic wb_retire(input UIntX data);
      do wb_id_ctr++; while (wb_id_ctr == IID_RANDOM);
      wb_valid = 1'b1; wb_inst_id = wb_id_ctr; wb_wdata = data;
      if (q_wr.size() > 0) begin
         wb_ctrl.rf_wen = REN_S; wb_ctrl.wb_addr = 5'(q_wr.pop_front());
      end else begin
         wb_ctrl.rf_wen = REN_X; wb_ctrl.wb_addr = 5'($urandom);
      end
   endtask

   task automatic drain();
      int n = 0;
      id_valid = 0; ds_ready = 1; flush = 0;
      while ((q_wr.size() > 0 || m_dsv) && n < 60) begin
         if (q_wr.size() > 0) wb_retire($urandom); else wb_valid = 0;
         step(); n++;
      end
      wb_valid = 0;
      step();
      if (q_wr.size() > 0 || m_dsv) begin
         miscompares++;
         $display("FAIL drain_timeout: %0d writes still pending", q_wr.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regfile[i] = 32'h1000 + 32'(i);
      regfile[0] = 32'hDEADBEEF;
      reset = 1; flush = 0; id_valid = 0; ds_ready = 1; wb_valid = 0;
      id_pc = '0; id_inst = '0; id_inst_id = '0; id_ctrl = '0; id_rs1 = '0; id_rs2 = '0;
      wb_inst_id = '0; wb_ctrl = '0; wb_wdata = '0;
      model_reset();
      step(); step();
      chk("rst_ds_valid", 32'(ds_valid), 32'd0);
      chk("rst_ds_op1", ds_op1, 32'd0);
      reset = 0;

      // Independent back-to-back stream
      offer(10, 1, 6, 7); step();
      offer(11, 1, 6, 7); step();
      offer(12, 1, 6, 7); step();
      chk("indep_op2", ds_op2, 32'h1007);
      id_valid = 0; step();
      drain();

      // RAW hazard resolved by forwarding in the retire cycle
      offer(5, 1, 1, 2); step();
      offer(20, 1, 5, 0); step(); step();
      chk("raw_stall", 32'(id_ready), 32'd0);
      wb_retire(32'h1234); step();
      chk("raw_fire", 32'(ds_valid), 32'd1);
      chk("raw_op1", ds_op1, 32'h1234);
      wb_valid = 0; id_valid = 0; step();
      drain();

      // Back-pressure holds the output register
      offer(8, 1, 1, 2); step();
      held_pc = ds_pc;
      offer(0, 0, 1, 0); ds_ready = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("bp_ready", 32'(id_ready), 32'd0);
         chk("bp_pc", ds_pc, held_pc);
      end
      id_valid = 0; ds_ready = 1; step();
      chk("bp_pend8", 32'(dut.u_sb.pend[8]), 32'd1);

      // Repeated writeback id retires once
      wb_retire(32'h55); step(); step(); step(); step();
      chk("dup_pend8", 32'(dut.u_sb.pend[8]), 32'd0);
      wb_valid = 0; step();

      // Flush discards an uncounted writer
      offer(9, 1, 0, 0); step();
      id_valid = 0; flush = 1; step();
      flush = 0;
      chk("fl_pend9", 32'(dut.u_sb.pend[9]), 32'd0);
      offer(21, 0, 9, 9); step();
      chk("fl_reader", 32'(ds_valid), 32'd1);
      id_valid = 0; step();
      drain();

      // x0 reads and destination saturation
      offer(0, 1, 0, 0); step();
      offer(22, 0, 0, 0); step();
      chk("x0_op1", ds_op1, 32'd0);
      chk("x0_op2", ds_op2, 32'd0);
      offer(3, 1, 0, 0); step(); step(); step(); step();
      chk("sat_stall", 32'(id_ready), 32'd0);
      step();
      wb_retire(32'h77); step();
      chk("sat_fire", 32'(ds_valid), 32'd1);
      chk("sat_rd", 32'(ds_ctrl.wb_addr), 32'd3);
      wb_valid = 0; id_valid = 0; step();
      drain();

      // Randomized traffic
      for (int t = 0; t < 400; t++) begin
         int r;
         if (!id_valid || m_fired) begin
            if ($urandom_range(0, 3) != 0)
               offer($urandom_range(0, 7), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 7), $urandom_range(0, 7));
            else id_valid = 0;
         end
         r = $urandom_range(0, 9);
         if (r < 5) wb_retire($urandom);
         else if (r >= 7) wb_valid = 0;
         ds_ready = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 19) == 0);
         step();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Operand-read stage between decode and execute: the reading end of the register file that the writeback stage writes. Accepts decoded instructions over a valid/ready handshake and reads `rs1`/`rs2` from `regfile`, forwarding the writeback stage's same-cycle write data. A per-register scoreboard of in-flight writes stalls reads of stale registers. Results are registered and handed to execute over a second valid/ready handshake.

## Interface
Parameters:
- `SB_CNT_W`, 2: width of each per-register pending-write counter; at most 2^SB_CNT_W−1 in-flight writes to one register.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `regfile` in UIntX[31:0]: architectural registers, owned by writeback.
- `flush` in 1: discard the instruction held in the output register.
- `id_valid` in 1: decode offers an instruction.
- `id_ready` out 1: this stage accepts it this cycle.
- `id_pc` in Addr: instruction address.
- `id_inst` in Inst: instruction word.
- `id_inst_id` in IId: instruction identifier.
- `id_ctrl` in Ctrl: decoded control; uses `rf_wen` and `wb_addr`.
- `id_rs1` in 5: source register 1 index.
- `id_rs2` in 5: source register 2 index.
- `wb_valid` in 1: writeback stage holds a valid instruction.
- `wb_inst_id` in IId: identifier of the instruction in writeback.
- `wb_ctrl` in Ctrl: writeback control (`rf_wen`, `wb_addr`).
- `wb_wdata` in UIntX: writeback data (the `wb_wdata_out` value).
- `ds_valid` out 1: output register holds an instruction for execute.
- `ds_ready` in 1: execute accepts it.
- `ds_pc` out Addr: registered copy of `id_pc`.
- `ds_inst` out Inst: registered copy of `id_inst`.
- `ds_inst_id` out IId: registered copy of `id_inst_id`.
- `ds_ctrl` out Ctrl: registered copy of `id_ctrl`.
- `ds_op1` out UIntX: resolved operand 1.
- `ds_op2` out UIntX: resolved operand 2.

## Operation
- **Retire detection:** `wb_new = wb_valid && wb_inst_id != saved_wb_id`. `saved_wb_id` loads `wb_inst_id` whenever `wb_valid`; reset value is IID_RANDOM. This matches writeback's own new-instruction rule exactly.
- **Retire event:** `wb_new && wb_ctrl.rf_wen == REN_S && wb_ctrl.wb_addr != 0`. It decrements `pend[wb_addr]`.
- **Issue event:** `ds_valid && ds_ready && ds_ctrl.rf_wen == REN_S && ds_ctrl.wb_addr != 0`. It increments `pend[ds_ctrl.wb_addr]`.
- **Same-register set and clear in one cycle:** the counter is unchanged.
- **Register x0:** `pend[0]` is always 0 and operand x0 always reads 0.
- **Operand resolution, per source s:**
  - s == 0 → 0.
  - Else if a retire event targets s this cycle → `wb_wdata` (forward; `regfile` is not yet updated).
  - Else → `regfile[s]`.
- **Source s blocked when either holds:**
  - `pend[s]` minus a retire to s this cycle is greater than 0.
  - The output register holds an instruction (`ds_valid`) that writes s, since it is not yet counted.
- **Destination blocked when:** `pend[rd]` is at its maximum value and an instruction writing rd would overflow it.
- **Handshake:** `id_ready = !(rs1 blocked || rs2 blocked || rd blocked) && (!ds_valid || ds_ready) && !flush`.
- **On `id_valid && id_ready`:** the output register loads all fields plus the resolved operands, and `ds_valid` goes to 1.
- **On `ds_valid && ds_ready` with no new fire:** `ds_valid` goes to 0.
- **Stall stability:** while `ds_valid && !ds_ready`, all `ds_*` outputs hold stable.
- **`flush`:** clears `ds_valid` next cycle and does not count the discarded instruction.
  - Scoreboard entries for older instructions already past this stage remain and retire normally.
  - A concurrent retire is still applied.
- **Reset:** `ds_valid`=0, all `pend`=0, `saved_wb_id`=IID_RANDOM. Other `ds_*` outputs are don't-care and are driven 0.

## Timing
- Latency is 1 cycle from `id` fire to `ds_valid`.
- Throughput is 1 instruction per cycle when there is no hazard.
- Forwarding is combinational from the `wb_*` inputs to the operand mux, captured at the same edge as writeback's `regfile` write.
- A dependent instruction unblocks in the cycle its producer's retire event occurs. There is no extra bubble beyond that.
- `id_ready` is combinational from `ds_ready`, `flush`, the `wb_*` inputs, and state. It has no combinational dependence on `id_valid`.
- Reset asserted mid-operation wins over every event in that cycle.

## Structure
- Shared package (existing basicparams):
  - Types: UIntX, Addr, Inst, IId, Ctrl.
  - Constants: REN_S, IID_RANDOM.
  - Add constant `REG_COUNT` = 32.
- Sub-module `reg_scoreboard`, containing:
  - The pending counters.
  - Retire detection.
  - Ports: issue/retire strobes and addresses; query outputs `busy1`, `busy2`, `full_rd`.
- The top level holds the forwarding muxes, handshake logic and output register.

## Test plan
- **Independent stream:** after reset, issue addi x5, x6, x7 back-to-back with `ds_ready`=1 → one `ds_valid` per cycle; operands equal `regfile` values; `id_ready` stays 1.
- **Read-after-write via forwarding:** x5 writer issued, then a reader of x5 → reader stalls until the x5 retire event with `wb_wdata`=0x1234. It fires in that same cycle with `ds_op1`=0x1234, while `regfile[5]` still shows the old value.
- **Back-pressure:** `ds_ready`=0 for 3 cycles → `id_ready`=0 and `ds_*` stable; on release the instruction is issued exactly once and `pend` increments by exactly 1.
- **Duplicate writeback ID:** `wb_valid` held 4 cycles with the same `wb_inst_id` → `pend` decrements only once.
- **Flush:** an x9 writer is in the output register and `flush`=1 → `ds_valid`=0 next cycle, `pend[9]` stays 0, and a following reader of x9 is not stalled.
- **x0 and saturation:** reads of x0 give 0 and never stall, even with a writer to x0 in flight. Three writes to x3 in flight (`SB_CNT_W`=2) → a fourth x3 writer stalls until one retires.
